// File: rtl/gray_sum_accumulator.sv
// gray_sum_accumulator: takes gray-coded sums (plus carry-out) from the gray-code adder.
// Each accepted sample is decoded to binary and added into a running accumulator.
// The total is presented in gray code through a one-entry registered output stage.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   upstream handshake; in_ready = !out_valid | out_ready
//   in_sum, in_co       gray sum and binary carry-out (weight 2^WIDTH), sampled on accept
//   clear               synchronous clear of accumulator, overflow flag and counter
//   out_valid/out_ready downstream handshake
//   out_acc             running total, gray-coded
//   out_ovf             sticky wrap flag
//   out_cnt             saturating count of accepted samples
module gray_sum_accumulator #(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned ACC_WIDTH = 8,
   parameter int unsigned CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_sum,
   input  logic                 in_co,
   input  logic                 clear,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] out_acc,
   output logic                 out_ovf,
   output logic [CNT_WIDTH-1:0] out_cnt
);

   localparam int unsigned ADD_WIDTH = WIDTH + 1;
   localparam int unsigned SUM_WIDTH = ACC_WIDTH + 1;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t                 state;
   logic [ACC_WIDTH-1:0]   acc;
   logic [WIDTH-1:0]       bin_sum;
   logic [ACC_WIDTH-1:0]   addend;
   logic [SUM_WIDTH-1:0]   sum_ext;
   logic [ACC_WIDTH-1:0]   next_acc;
   logic                   accept;

   // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
   always_comb begin
      bin_sum = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         bin_sum[i] = ^(in_sum >> i);
      end
   end

   // Addend, widened add and handshake decode.
   always_comb begin
      addend   = ACC_WIDTH'({in_co, bin_sum});
      sum_ext  = SUM_WIDTH'(acc) + SUM_WIDTH'(addend);
      next_acc = sum_ext[ACC_WIDTH-1:0];
      in_ready = (state == EMPTY) || out_ready;
      accept   = in_valid && in_ready;
   end

   assign out_valid = (state == FULL);

   // Output stage, accumulator and statistics; clear outranks accumulation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= EMPTY;
         acc     <= '0;
         out_acc <= '0;
         out_ovf <= 1'b0;
         out_cnt <= '0;
      end else if (clear) begin
         out_ovf <= 1'b0;
         if (accept) begin
            state   <= FULL;
            acc     <= addend;
            out_acc <= addend ^ (addend >> 1);
            out_cnt <= CNT_WIDTH'(1);
         end else begin
            state   <= EMPTY;
            acc     <= '0;
            out_acc <= '0;
            out_cnt <= '0;
         end
      end else if (accept) begin
         state   <= FULL;
         acc     <= next_acc;
         out_acc <= next_acc ^ (next_acc >> 1);
         out_ovf <= out_ovf | sum_ext[ACC_WIDTH];
         if (out_cnt != '1) begin
            out_cnt <= out_cnt + CNT_WIDTH'(1);
         end
      end else if (out_ready) begin
         // Release without a new sample empties the stage (no-op when already empty).
         state <= EMPTY;
      end
   end

endmodule

// File: tb/tb_gray_sum_accumulator.sv
// Self-checking bench for gray_sum_accumulator: directed scenarios followed by
// randomized traffic, all compared against an arithmetic reference model.
module tb_gray_sum_accumulator;

   localparam int unsigned WIDTH     = 4;
   localparam int unsigned ACC_WIDTH = 8;
   localparam int unsigned CNT_WIDTH = 8;
   localparam int unsigned ACC_MOD   = 256;
   localparam int unsigned CNT_MAX   = 255;

   logic                 clk;
   logic                 rst_n;
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_sum;
   logic                 in_co;
   logic                 clear;
   logic                 out_valid;
   logic                 out_ready;
   logic [ACC_WIDTH-1:0] out_acc;
   logic                 out_ovf;
   logic [CNT_WIDTH-1:0] out_cnt;

   int unsigned n_checks;
   int unsigned n_errors;

   // Reference model state: plain integers.
   bit          m_full;
   int unsigned m_total;
   bit          m_ovf;
   int unsigned m_cnt;

   gray_sum_accumulator #(
      .WIDTH    (WIDTH),
      .ACC_WIDTH(ACC_WIDTH),
      .CNT_WIDTH(CNT_WIDTH)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_sum   (in_sum),
      .in_co    (in_co),
      .clear    (clear),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_acc  (out_acc),
      .out_ovf  (out_ovf),
      .out_cnt  (out_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int unsigned to_gray(input int unsigned v);
      return v ^ (v >> 1);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_full  = 1'b0;
      m_total = 0;
      m_ovf   = 1'b0;
      m_cnt   = 0;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".valid"}, 32'(out_valid), 32'(m_full));
      check({tag, ".acc"},   32'(out_acc),   to_gray(m_total));
      check({tag, ".ovf"},   32'(out_ovf),   32'(m_ovf));
      check({tag, ".cnt"},   32'(out_cnt),   m_cnt);
   endtask

   // One clock of traffic. Called at a falling edge; addend is the binary value
   // the upstream adder represents ({co, sum}), re-encoded here as gray + carry.
   task automatic step(input bit v, input int unsigned addend, input bit rdy, input bit clr);
      bit          acc_ok;
      int unsigned s;
      in_valid  = v;
      in_co     = 1'((addend >> 4) & 1);
      in_sum    = 4'(to_gray(addend & 15));
      out_ready = rdy;
      clear     = clr;
      #1;
      check("in_ready", 32'(in_ready), 32'(!m_full || rdy));
      acc_ok = v && (!m_full || rdy);
      @(posedge clk);
      if (clr) begin
         m_ovf = 1'b0;
         if (acc_ok) begin
            m_total = addend;
            m_cnt   = 1;
            m_full  = 1'b1;
         end else begin
            m_total = 0;
            m_cnt   = 0;
            m_full  = 1'b0;
         end
      end else if (acc_ok) begin
         s = m_total + addend;
         if (s >= ACC_MOD) m_ovf = 1'b1;
         m_total = s % ACC_MOD;
         if (m_cnt < CNT_MAX) m_cnt++;
         m_full = 1'b1;
      end else if (m_full && rdy) begin
         m_full = 1'b0;
      end
      @(negedge clk);
      check_outputs("step");
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_sum    = '0;
      in_co     = 1'b0;
      clear     = 1'b0;
      out_ready = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_outputs("reset");
      rst_n = 1'b1;
      #1;
      check("reset.in_ready", 32'(in_ready), 32'd1);

      // Single sample: gray 0111 -> 5, plus carry 16 -> 21.
      step(1'b1, 21, 1'b1, 1'b0);
      check("single.acc", 32'(out_acc), 32'h1F);
      check("single.cnt", 32'(out_cnt), 32'd1);

      // Wrap after the 13th identical sample.
      for (int i = 0; i < 11; i++) step(1'b1, 21, 1'b1, 1'b0);
      check("wrap12.acc", 32'(out_acc), 32'h82);
      check("wrap12.ovf", 32'(out_ovf), 32'd0);
      step(1'b1, 21, 1'b1, 1'b0);
      check("wrap13.acc", 32'(out_acc), 32'h19);
      check("wrap13.ovf", 32'(out_ovf), 32'd1);
      check("wrap13.cnt", 32'(out_cnt), 32'd13);

      // Backpressure: stage full, downstream stalled, upstream holding a sample.
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 9, 1'b0, 1'b0);
         check("bp.frozen", 32'(out_acc), 32'h19);
      end
      step(1'b1, 9, 1'b1, 1'b0);
      check("bp.release", 32'(out_acc), 32'(to_gray(26)));

      // Clear priority: build acc=100, then clear together with an accept.
      step(1'b0, 0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 31, 1'b1, 1'b0);
      step(1'b1, 7, 1'b1, 1'b0);
      check("clr.acc100", 32'(out_acc), 32'(to_gray(100)));
      step(1'b1, 21, 1'b1, 1'b1);
      check("clr_acc.acc", 32'(out_acc), 32'h1F);
      check("clr_acc.ovf", 32'(out_ovf), 32'd0);
      check("clr_acc.cnt", 32'(out_cnt), 32'd1);
      step(1'b0, 0, 1'b0, 1'b1);
      check("clr_only.valid", 32'(out_valid), 32'd0);
      step(1'b1, 3, 1'b1, 1'b0);
      check("clr_after.acc", 32'(out_acc), 32'h02);

      // Counter saturation with zero addends.
      step(1'b0, 0, 1'b1, 1'b1);
      for (int i = 0; i < 300; i++) step(1'b1, 0, 1'b1, 1'b0);
      check("sat.cnt", 32'(out_cnt), 32'd255);
      check("sat.acc", 32'(out_acc), 32'd0);

      // Asynchronous reset while full and stalled.
      step(1'b1, 17, 1'b1, 1'b0);
      step(1'b0, 0, 1'b0, 1'b0);
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_rel.in_ready", 32'(in_ready), 32'd1);
      step(1'b1, 3, 1'b0, 1'b0);
      check("rst_rel.acc", 32'(out_acc), 32'h02);
      check("rst_rel.cnt", 32'(out_cnt), 32'd1);

      // Randomized traffic.
      for (int i = 0; i < 2000; i++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 31),
              $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
